// File: rtl/decoder.sv
// Magma (GOST R 34.12-2015) 64-bit block decryptor, iterative, one Feistel round per clock.
// Latency: input handshake at edge T -> sm_tvalid_o high after edge T+32; one block per 34 cycles.
// Backpressure: ss_tready_o low from accept until the plaintext leaves; OUT holds while sm_tready_i=0.
module decoder #(
  parameter int                    TDATA_WIDTH = 64,
  parameter int                    KEY_WIDTH   = 256,
  parameter int                    K_WIDTH     = 32,
  parameter int                    R_WIDTH     = 32,
  parameter logic [KEY_WIDTH-1:0]  KEY         =
    256'hffeeddccbbaa99887766554433221100_f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ss_tvalid_i,
  input  logic [TDATA_WIDTH-1:0] ss_tdata_i,
  output logic                   ss_tready_o,
  output logic                   sm_tvalid_o,
  output logic [TDATA_WIDTH-1:0] sm_tdata_o,
  input  logic                   sm_tready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  // S-boxes pi0..pi7; entry j of each row sits at bits [63-4j -: 4] (entry 0 in the MSB nibble).
  localparam logic [63:0] PI [8] = '{
    64'hC462A5B9E8D703F1,
    64'h68239A5C1E47BD0F,
    64'hB3582FADE174C960,
    64'hC821D4F670A53E9B,
    64'h7F5A816D093EB42C,
    64'h5DF692CAB78143E0,
    64'h8E25691CF4B0DA37,
    64'h17ED05834FA69CB2
  };

  // g(k,a) = ROTL11(S(a + k mod 2^32)); pi0 substitutes the lowest nibble.
  function automatic logic [R_WIDTH-1:0] g_fn(input logic [K_WIDTH-1:0] k,
                                              input logic [R_WIDTH-1:0] a);
    logic [R_WIDTH-1:0] sum;
    logic [R_WIDTH-1:0] sub;
    sum = a + k;
    sub = '0;
    for (int n = 0; n < 8; n++) begin
      // entry j lives at bit offset (15-j)*4, and 15-j is just ~j for a nibble
      sub[4*n +: 4] = PI[n][{~sum[4*n +: 4], 2'b00} +: 4];
    end
    return {sub[20:0], sub[31:21]};
  endfunction

  state_t                 state_q;
  logic [4:0]             cnt_q;
  logic [R_WIDTH-1:0]     a1_q;
  logic [R_WIDTH-1:0]     a0_q;
  logic                   ss_tready_q;
  logic                   sm_tvalid_q;
  logic [TDATA_WIDTH-1:0] sm_tdata_q;

  logic [2:0]             key_idx;
  logic [K_WIDTH-1:0]     round_key;
  logic [R_WIDTH-1:0]     g_out;

  // Decrypt key order: K0..K7 once, then K7..K0 three times; K[i] is KEY word i from the top.
  always_comb begin
    key_idx   = (cnt_q < 5'd8) ? cnt_q[2:0] : ~cnt_q[2:0];
    round_key = KEY[{~key_idx, 5'd0} +: K_WIDTH];
    g_out     = g_fn(round_key, a0_q);
  end

  // Block FSM: load in IDLE, 32 rounds in CALC, hold the result in OUT until taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      a1_q        <= '0;
      a0_q        <= '0;
      ss_tready_q <= 1'b1;
      sm_tvalid_q <= 1'b0;
      sm_tdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_tvalid_i) begin
            a1_q        <= ss_tdata_i[63:32];
            a0_q        <= ss_tdata_i[31:0];
            cnt_q       <= 5'd0;
            ss_tready_q <= 1'b0;
            state_q     <= CALC;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            // last round skips the half swap
            sm_tdata_q  <= {a1_q ^ g_out, a0_q};
            sm_tvalid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            a1_q <= a0_q;
            a0_q <= a1_q ^ g_out;
          end
        end
        OUT: begin
          if (sm_tready_i) begin
            sm_tvalid_q <= 1'b0;
            ss_tready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ss_tready_o = ss_tready_q;
  assign sm_tvalid_o = sm_tvalid_q;
  assign sm_tdata_o  = sm_tdata_q;

endmodule

// File: tb/tb_decoder.sv
// Bench for the Magma decryptor: block-level cipher model plus per-cycle handshake model.
// Directed cases: reference vector, backpressure, busy input, resets, all-zero/all-one blocks.
// Random traffic: loopback of model-encrypted plaintext and raw random ciphertext.
module tb_decoder;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        ss_tvalid_i;
  logic [63:0] ss_tdata_i;
  logic        ss_tready_o;
  logic        sm_tvalid_o;
  logic [63:0] sm_tdata_o;
  logic        sm_tready_i;

  decoder dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .ss_tvalid_i (ss_tvalid_i),
    .ss_tdata_i  (ss_tdata_i),
    .ss_tready_o (ss_tready_o),
    .sm_tvalid_o (sm_tvalid_o),
    .sm_tdata_o  (sm_tdata_o),
    .sm_tready_i (sm_tready_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- cipher model ----------------
  logic [255:0] key_v = 256'hffeeddccbbaa99887766554433221100_f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

  int pi_t [8][16] = '{
    '{12, 4, 6, 2,10, 5,11, 9,14, 8,13, 7, 0, 3,15, 1},
    '{ 6, 8, 2, 3, 9,10, 5,12, 1,14, 4, 7,11,13, 0,15},
    '{11, 3, 5, 8, 2,15,10,13,14, 1, 7, 4,12, 9, 6, 0},
    '{12, 8, 2, 1,13, 4,15, 6, 7, 0,10, 5, 3,14, 9,11},
    '{ 7,15, 5,10, 8, 1, 6,13, 0, 9, 3,14,11, 4, 2,12},
    '{ 5,13,15, 6, 9, 2,12,10,11, 7, 8, 1, 4, 3,14, 0},
    '{ 8,14, 2, 5, 6, 9, 1,12,15, 4,11, 0,13,10, 3, 7},
    '{ 1, 7,14,13, 0, 5, 8, 3, 4,15,10, 6, 9,12,11, 2}
  };

  function automatic logic [31:0] subkey(input int i);
    logic [255:0] s;
    s = key_v >> (32 * (7 - i));
    return s[31:0];
  endfunction

  function automatic logic [31:0] gfun(input logic [31:0] k, input logic [31:0] a);
    logic [31:0] sum;
    logic [31:0] t;
    sum = a + k;
    t = 32'd0;
    for (int n = 0; n < 8; n++) begin
      t = t | (32'(pi_t[n][(sum >> (4 * n)) & 32'hF]) << (4 * n));
    end
    return (t << 11) | (t >> 21);
  endfunction

  // Encryption uses K1..K8 three times then K8..K1; decryption walks that sequence backwards.
  function automatic logic [63:0] feistel(input logic [63:0] blk, input bit dec);
    logic [31:0] a1, a0, t, k;
    int e;
    a1 = blk[63:32];
    a0 = blk[31:0];
    for (int r = 0; r < 31; r++) begin
      e  = dec ? 31 - r : r;
      k  = subkey(e < 24 ? e % 8 : 31 - e);
      t  = a1 ^ gfun(k, a0);
      a1 = a0;
      a0 = t;
    end
    e = dec ? 0 : 31;
    k = subkey(e < 24 ? e % 8 : 31 - e);
    return {a1 ^ gfun(k, a0), a0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- handshake model (updated at posedge) ----------------
  bit          live = 1'b0;
  bit          exp_rdy = 1'b1;
  bit          exp_vld = 1'b0;
  logic [63:0] exp_dat = 64'd0;
  logic [63:0] m_pend = 64'd0;
  int          m_wait = 0;
  logic [63:0] orig_q [$];

  always @(posedge clk) begin
    if (rst_i === 1'b1) begin
      live    = 1'b1;
      exp_rdy = 1'b1;
      exp_vld = 1'b0;
      exp_dat = 64'd0;
      m_wait  = 0;
      orig_q.delete();
    end else if (exp_rdy && ss_tvalid_i) begin
      exp_rdy = 1'b0;
      m_pend  = feistel(ss_tdata_i, 1'b1);
      m_wait  = 32;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        exp_vld = 1'b1;
        exp_dat = m_pend;
      end
    end else if (exp_vld && sm_tready_i) begin
      exp_vld = 1'b0;
      exp_rdy = 1'b1;
    end
  end

  // Single compare process: outputs vs model every cycle, plus in-order scoreboard on each transfer.
  always @(negedge clk) begin
    if (live) begin
      chk("cyc_ss_tready", {63'd0, ss_tready_o}, {63'd0, exp_rdy});
      chk("cyc_sm_tvalid", {63'd0, sm_tvalid_o}, {63'd0, exp_vld});
      chk("cyc_sm_tdata", sm_tdata_o, exp_dat);
      if (sm_tvalid_o === 1'b1 && sm_tready_i === 1'b1 && rst_i === 1'b0) begin
        if (orig_q.size() == 0) begin
          chk("sb_unexpected_out", sm_tdata_o, 64'hx);
        end else begin
          chk("sb_order_data", sm_tdata_o, orig_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  initial begin
    sm_tready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       sm_tready_i = 1'b0;
        1:       sm_tready_i = 1'b1;
        default: sm_tready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input logic [63:0] ct, input logic [63:0] pt);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #2;
    ss_tvalid_i = 1'b1;
    ss_tdata_i  = ct;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (ss_tready_o === 1'b1) ok = 1'b1;
    end
    if (!ok) fail_now("send_accept");
    @(posedge clk);
    if (ok) orig_q.push_back(pt);
    #2;
    ss_tvalid_i = 1'b0;
    ss_tdata_i  = {$urandom, $urandom};
  endtask

  task automatic wait_out();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (sm_tvalid_o === 1'b1) ok = 1'b1;
    end
    if (!ok) fail_now("wait_out");
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (ss_tready_o === 1'b1) ok = 1'b1;
    end
    if (!ok) fail_now("wait_ready");
  endtask

  initial begin
    int          lat;
    logic [63:0] hold, pt, ct, vals [2];

    rst_i       = 1'b1;
    ss_tvalid_i = 1'b0;
    ss_tdata_i  = 64'd0;
    repeat (3) @(posedge clk);
    #2;
    rst_i = 1'b0;

    // reset state
    chk("reset_ss_tready", {63'd0, ss_tready_o}, 64'd1);
    chk("reset_sm_tvalid", {63'd0, sm_tvalid_o}, 64'd0);
    chk("reset_sm_tdata", sm_tdata_o, 64'd0);

    // pin the model on the published vector
    chk("model_decrypt_rfc", feistel(64'h4ee901e5c2d8ca3d, 1'b1), 64'hfedcba9876543210);
    chk("model_encrypt_rfc", feistel(64'hfedcba9876543210, 1'b0), 64'h4ee901e5c2d8ca3d);

    // reference vector and exact latency
    send(64'h4ee901e5c2d8ca3d, 64'hfedcba9876543210);
    lat = 0;
    while (sm_tvalid_o !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk("rfc_latency", 64'(lat), 64'd32);
    chk("rfc_data", sm_tdata_o, 64'hfedcba9876543210);
    wait_ready();

    // backpressure: 50 cycles stalled in OUT
    rdy_mode = 0;
    ct = {$urandom, $urandom};
    send(ct, feistel(ct, 1'b1));
    wait_out();
    hold = sm_tdata_o;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      chk("bp_data_stable", sm_tdata_o, hold);
      chk("bp_tvalid_high", {63'd0, sm_tvalid_o}, 64'd1);
      chk("bp_tready_low", {63'd0, ss_tready_o}, 64'd0);
    end
    rdy_mode = 1;
    wait_ready();

    // busy input: valid held with changing data while the core is computing
    ct = {$urandom, $urandom};
    send(ct, feistel(ct, 1'b1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      ss_tvalid_i = 1'b1;
      ss_tdata_i  = {$urandom, $urandom};
    end
    pt = {$urandom, $urandom};
    send(feistel(pt, 1'b0), pt);
    wait_out();
    chk("busy_second_block", sm_tdata_o, pt);
    wait_ready();

    // reset while round 10 is being computed
    ct = {$urandom, $urandom};
    send(ct, feistel(ct, 1'b1));
    repeat (10) @(posedge clk);
    #2;
    rst_i = 1'b1;
    @(posedge clk);
    #2;
    rst_i = 1'b0;
    chk("midrst_sm_tvalid", {63'd0, sm_tvalid_o}, 64'd0);
    chk("midrst_ss_tready", {63'd0, ss_tready_o}, 64'd1);
    send(64'h4ee901e5c2d8ca3d, 64'hfedcba9876543210);
    wait_out();
    chk("midrst_next_block", sm_tdata_o, 64'hfedcba9876543210);
    wait_ready();

    // reset coinciding with a handshake: no transfer
    @(posedge clk);
    #2;
    rst_i       = 1'b1;
    ss_tvalid_i = 1'b1;
    ss_tdata_i  = 64'h4ee901e5c2d8ca3d;
    @(posedge clk);
    #2;
    rst_i       = 1'b0;
    ss_tvalid_i = 1'b0;
    chk("rst_hs_ss_tready", {63'd0, ss_tready_o}, 64'd1);
    repeat (3) @(posedge clk);

    // all-zero and all-one ciphertext round trip through the encryptor model
    vals[0] = 64'd0;
    vals[1] = ~64'd0;
    for (int v = 0; v < 2; v++) begin
      send(vals[v], feistel(vals[v], 1'b1));
      wait_out();
      chk("edge_reencrypt", feistel(sm_tdata_o, 1'b0), vals[v]);
      wait_ready();
    end

    // random traffic with random downstream stalls
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      if (i % 2 == 0) begin
        pt = {$urandom, $urandom};
        send(feistel(pt, 1'b0), pt);
      end else begin
        ct = {$urandom, $urandom};
        send(ct, feistel(ct, 1'b1));
      end
    end
    for (int i = 0; i < 2000 && orig_q.size() != 0; i++) @(posedge clk);
    rdy_mode = 1;
    repeat (3) @(posedge clk);
    chk("drain_outstanding", 64'(orig_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
